// File: rtl/ppa_pipe_adder.sv
// Pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready
// handshakes. Prefix rows are built in a generate loop. A stage register is
// inserted after every REG_EVERY rows, and a final output register follows
// post-processing. Index 0 of each g vector is the carry-in node (bit -1).
module ppa_pipe_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 2,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  // Number of prefix rows over WIDTH+1 nodes (operand bits plus carry-in)
  localparam int unsigned R  = $clog2(WIDTH + 1);
  localparam int unsigned DF = 1 << (R - 1);

  logic [WIDTH-1:0] b_eff;
  logic             adv_fin;

  assign b_eff = sub ? ~b : b;

  // Rows 0..R-1. Row 0 is pre-processing; row R is folded into the output stage.
  // After row k, nodes below 2^k are fully resolved, so only p[WIDTH:2^k] is kept.
  for (genvar k = 0; k < R; k++) begin : g_row
    logic [WIDTH:0]        g_o;
    logic [WIDTH:(1 << k)] p_o;
    logic [WIDTH-1:0]      praw_o;
    logic                  am_o;
    logic                  bm_o;
    logic [TAG_W-1:0]      tag_o;
    logic                  vld_o;
    logic                  adv_up;
    logic                  adv_dn;

    if (k == R - 1) begin : g_last
      assign adv_dn = adv_fin;
    end else begin : g_next
      assign adv_dn = g_row[k+1].adv_up;
    end

    if (k == 0) begin : g_pre
      assign g_o    = {a & b_eff, cin ^ sub};
      assign p_o    = a ^ b_eff;
      assign praw_o = a ^ b_eff;
      assign am_o   = a[WIDTH-1];
      assign bm_o   = b_eff[WIDTH-1];
      assign tag_o  = in_tag;
      assign vld_o  = in_valid;
      assign adv_up = adv_dn;
    end else begin : g_pfx
      localparam int unsigned D       = 1 << (k - 1);
      localparam bit          HAS_REG = ((k % REG_EVERY) == 0);

      logic [WIDTH:0]        g_c;
      logic [WIDTH:(1 << k)] p_c;

      // Grey cells for nodes whose span reaches the carry-in, black cells above
      always_comb begin
        g_c = g_row[k-1].g_o;
        p_c = '0;
        for (int unsigned n = D; (n < 2 * D) && (n <= WIDTH); n++) begin
          g_c[n] = g_row[k-1].g_o[n] | (g_row[k-1].p_o[n] & g_row[k-1].g_o[n-D]);
        end
        for (int unsigned n = 2 * D; n <= WIDTH; n++) begin
          g_c[n] = g_row[k-1].g_o[n] | (g_row[k-1].p_o[n] & g_row[k-1].g_o[n-D]);
          p_c[n] = g_row[k-1].p_o[n] & g_row[k-1].p_o[n-D];
        end
      end

      if (HAS_REG) begin : g_reg
        logic [WIDTH:0]        g_q;
        logic [WIDTH:(1 << k)] p_q;
        logic [WIDTH-1:0]      praw_q;
        logic                  am_q;
        logic                  bm_q;
        logic [TAG_W-1:0]      tag_q;
        logic                  vld_q;

        // Stage register: loads when it can drain, otherwise holds its contents
        always_ff @(posedge clk) begin
          if (rst) begin
            vld_q <= 1'b0;
          end else if (adv_up) begin
            vld_q <= g_row[k-1].vld_o;
            if (g_row[k-1].vld_o) begin
              g_q    <= g_c;
              p_q    <= p_c;
              praw_q <= g_row[k-1].praw_o;
              am_q   <= g_row[k-1].am_o;
              bm_q   <= g_row[k-1].bm_o;
              tag_q  <= g_row[k-1].tag_o;
            end
          end
        end

        assign g_o    = g_q;
        assign p_o    = p_q;
        assign praw_o = praw_q;
        assign am_o   = am_q;
        assign bm_o   = bm_q;
        assign tag_o  = tag_q;
        assign vld_o  = vld_q;
        assign adv_up = !vld_q || adv_dn;
      end else begin : g_comb
        assign g_o    = g_c;
        assign p_o    = p_c;
        assign praw_o = g_row[k-1].praw_o;
        assign am_o   = g_row[k-1].am_o;
        assign bm_o   = g_row[k-1].bm_o;
        assign tag_o  = g_row[k-1].tag_o;
        assign vld_o  = g_row[k-1].vld_o;
        assign adv_up = adv_dn;
      end
    end
  end

  assign in_ready = g_row[0].adv_up;

  logic [WIDTH:0]   g_fin;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [TAG_W-1:0] tag_q;

  // Last prefix row (all grey) and post-processing
  always_comb begin
    g_fin = g_row[R-1].g_o;
    for (int unsigned n = DF; n <= WIDTH; n++) begin
      g_fin[n] = g_row[R-1].g_o[n] | (g_row[R-1].p_o[n] & g_row[R-1].g_o[n-DF]);
    end
    sum_d  = g_row[R-1].praw_o ^ g_fin[WIDTH-1:0];
    cout_d = g_fin[WIDTH];
    ovf_d  = (g_row[R-1].am_o == g_row[R-1].bm_o) && (sum_d[WIDTH-1] != g_row[R-1].am_o);
  end

  assign adv_fin = out_ready || !out_valid_q;

  // Output register: holds the result until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tag_q       <= '0;
    end else if (adv_fin) begin
      out_valid_q <= g_row[R-1].vld_o;
      if (g_row[R-1].vld_o) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        tag_q  <= g_row[R-1].tag_o;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_tag   = tag_q;

endmodule
